// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter, LSB first, fixed baud divider,
// fed by a small FIFO so a producer can burst bytes on a strobe.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   tx_data[7:0] byte to queue, sampled with tx_trig
//   tx_trig      write strobe, one byte per high cycle
//   tx_full      FIFO full; writes dropped while high
//   tx_busy      high while a frame is on the line
//   flag_tx_end  one-cycle pulse after each stop bit ends
//   rs232_tx     registered serial line, idle high
module uart_tx #(
    parameter int BAUD_END = 5208,
    parameter int FIFO_AW  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_trig,
    output logic       tx_full,
    output logic       tx_busy,
    output logic       flag_tx_end,
    output logic       rs232_tx
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = $clog2(BAUD_END);

    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);
    localparam logic [CW-1:0]    C0_END  = CW'(BAUD_END - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t state;
    state_t state_nx;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;

    logic [CW-1:0] cnt0;
    logic [3:0]    cnt1;
    logic [9:0]    shreg;

    logic wr_en;
    logic pop;
    logic empty;
    logic cnt0_wrap;
    logic frame_end;

    assign tx_full   = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign wr_en     = tx_trig && !tx_full;
    assign cnt0_wrap = (state == SEND) && (cnt0 == C0_END);
    assign frame_end = cnt0_wrap && (cnt1 == 4'd9);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A pop both loads the shift register and advances the FIFO.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    state_nx = SEND;
                end
            end
            SEND: begin
                if (frame_end) begin
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !pop) begin
                count <= count + 1'b1;
            end else if (!wr_en && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (state == SEND) begin
            if (cnt0_wrap) begin
                cnt0 <= '0;
                cnt1 <= frame_end ? 4'd0 : cnt1 + 1'b1;
            end else begin
                cnt0 <= cnt0 + 1'b1;
            end
        end else begin
            cnt0 <= '0;
            cnt1 <= '0;
        end
    end

    // shreg[0] is the bit on the line; shreg[1] is the next one.
    // A pop at frame end restarts with a start bit, no idle gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg       <= '1;
            rs232_tx    <= 1'b1;
            tx_busy     <= 1'b0;
            flag_tx_end <= 1'b0;
        end else begin
            flag_tx_end <= frame_end;
            if (pop) begin
                shreg    <= {1'b1, mem[rd_ptr], 1'b0};
                rs232_tx <= 1'b0;
                tx_busy  <= 1'b1;
            end else if (frame_end) begin
                shreg    <= '1;
                rs232_tx <= 1'b1;
                tx_busy  <= 1'b0;
            end else if (cnt0_wrap) begin
                shreg    <= {1'b1, shreg[9:1]};
                rs232_tx <= shreg[1];
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with BAUD_END=16, FIFO_AW=2.
// Expected bytes queue on write and are checked as frames appear.
module tb_uart_tx;

    localparam int B = 16;
    localparam int F = 10 * B;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_trig = 1'b0;
    logic       tx_full;
    logic       tx_busy;
    logic       flag_tx_end;
    logic       rs232_tx;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q [$];

    uart_tx #(
        .BAUD_END(B),
        .FIFO_AW (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_trig    (tx_trig),
        .tx_full    (tx_full),
        .tx_busy    (tx_busy),
        .flag_tx_end(flag_tx_end),
        .rs232_tx   (rs232_tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t",
                   tag, obs, exp, $time);
        end
    endtask

    // Leaves the bench 1 ns after a rising edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write(input logic [7:0] b, input bit acc);
        tx_data = b;
        tx_trig = 1'b1;
        if (acc) exp_q.push_back(b);
        tick();
        tx_trig = 1'b0;
    endtask

    task automatic idle_chk(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_tx"}, rs232_tx, 1);
            chk({tag, "_busy"}, tx_busy, 0);
            chk({tag, "_flag"}, flag_tx_end, 0);
            chk({tag, "_full"}, tx_full, 0);
            tick();
        end
    endtask

    // Called just after the start-bit edge, or `skip` cycles later.
    // Returns just after the frame-end edge.
    task automatic frame_chk(input string tag, input int skip);
        logic [7:0] b;
        logic [9:0] fr;
        b = 8'h00;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 8'd0, 8'd1);
        end else begin
            b = exp_q.pop_front();
        end
        fr = {1'b1, b, 1'b0};
        for (int n = skip; n < F; n++) begin
            if ((n % B) == 0 || (n % B) == B - 1)
                chk({tag, "_bit"}, rs232_tx, fr[n / B]);
            if ((n % B) == B / 2) begin
                chk({tag, "_busy"}, tx_busy, 1);
                chk({tag, "_flagmid"}, flag_tx_end, 0);
            end
            tick();
        end
    endtask

    task automatic end_chk(input string tag, input bit more);
        chk({tag, "_flag"}, flag_tx_end, 1);
        chk({tag, "_busy"}, tx_busy, more);
        chk({tag, "_tx"}, rs232_tx, !more);
    endtask

    initial begin
        tick(2);
        rst = 1'b0;
        chk("rst_tx", rs232_tx, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_full", tx_full, 0);
        chk("rst_flag", flag_tx_end, 0);
        tick();

        idle_chk("idle", 1000);

        // Single byte
        write(8'h55, 1'b1);
        chk("one_pre_tx", rs232_tx, 1);
        chk("one_pre_busy", tx_busy, 0);
        tick();
        frame_chk("one", 0);
        end_chk("one_end", 1'b0);
        tick();
        chk("one_flag_off", flag_tx_end, 0);
        tick(5);

        // Back-to-back
        write(8'hA5, 1'b1);
        write(8'h3C, 1'b1);
        frame_chk("b2b_a", 0);
        end_chk("b2b_a_end", 1'b1);
        frame_chk("b2b_b", 0);
        end_chk("b2b_b_end", 1'b0);
        tick(5);

        // Overflow
        for (int i = 1; i <= 6; i++) begin
            write(8'(i), i <= 5);
            chk("ovf_full", tx_full, (i >= 5) ? 1 : 0);
        end
        chk("ovf_tx", rs232_tx, 0);
        frame_chk("ovf1", 4);
        chk("ovf_full_fall", tx_full, 0);
        end_chk("ovf1_end", 1'b1);
        for (int i = 2; i <= 5; i++) begin
            frame_chk("ovfn", 0);
            end_chk("ovfn_end", i != 5);
        end
        chk("ovf_q_empty", 8'(exp_q.size()), 0);
        tick();

        // Extremes
        write(8'h00, 1'b1);
        write(8'hFF, 1'b1);
        frame_chk("ext0", 0);
        end_chk("ext0_end", 1'b1);
        frame_chk("extf", 0);
        end_chk("extf_end", 1'b0);
        tick();
        idle_chk("ext_idle", 200);

        // Reset mid-frame, during bit 4
        write(8'h00, 1'b1);
        write(8'h00, 1'b1);
        tick(4 * B + 8);
        chk("mid_busy", tx_busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        chk("mrst_tx", rs232_tx, 1);
        chk("mrst_busy", tx_busy, 0);
        chk("mrst_full", tx_full, 0);
        chk("mrst_flag", flag_tx_end, 0);
        idle_chk("mrst_idle", 2 * F);
        write(8'h81, 1'b1);
        tick();
        frame_chk("post", 0);
        end_chk("post_end", 1'b0);
        tick();
        idle_chk("final", 50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-serial UART transmitter with a small input FIFO. It drives the RS-232 TX line in the same frame format the design's UART receiver expects: 8N1, LSB first, fixed baud divider. It sits between the on-chip data source (SDRAM readback / test logic) and the board TX pin, and accepts bytes on a one-cycle strobe. A FIFO absorbs short bursts so the producer never waits per byte.

## Interface
- BAUD_END, 5208: clock cycles per bit (50 MHz / 9600 baud). Must be ≥ 2.
- FIFO_AW, 2: FIFO address width; depth = 2^FIFO_AW entries.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset; one clock, synchronous, active-high.
- tx_data  input  8  byte to send; sampled when tx_trig is high.
- tx_trig  input  1  write strobe; one byte per cycle it is high.
- tx_full  output  1  FIFO full; writes are dropped while high.
- tx_busy  output  1  high while a frame is on the line.
- flag_tx_end  output  1  one-cycle pulse when a stop bit completes.
- rs232_tx  output  1  serial line, idle high; registered output.

## Operation
- Reset values: rs232_tx=1, tx_busy=0, tx_full=0, flag_tx_end=0. FIFO pointers and count are 0, the FSM is IDLE, and all counters are 0.
- FIFO:
  - Write occurs when tx_trig && !tx_full. tx_full is evaluated before the edge.
  - A write while full is silently dropped, including when a pop occurs in the same cycle. Stored data is never overwritten.
  - Count width is FIFO_AW+1. tx_full = (count == 2^FIFO_AW).
  - A simultaneous write and pop with count ≥ 1 leaves count unchanged.
- Frame: 10 bits, each held for exactly BAUD_END cycles. Order: start bit (0), then data[0]..data[7], then stop bit (1).
- Counters:
  - cnt0 runs 0..BAUD_END-1 only in SEND.
  - cnt1 is the bit index 0..9. It increments when cnt0 wraps.
  - end of frame = (cnt0 == BAUD_END-1) && (cnt1 == 9).
- FSM states are IDLE and SEND.
  - IDLE, FIFO non-empty: pop the head into a 10-bit shift register {1, data, 0}, set rs232_tx=0 and tx_busy=1, go to SEND.
  - IDLE, FIFO empty: hold rs232_tx=1.
  - SEND: on each cnt0 wrap, shift and drive the next bit onto rs232_tx.
  - SEND, end of frame with FIFO non-empty: pop and load the next byte in the same cycle. rs232_tx goes to 0 at that edge (no idle gap). tx_busy stays 1. Stay in SEND.
  - SEND, end of frame with FIFO empty: rs232_tx=1, tx_busy=0, go to IDLE.
- flag_tx_end = 1 for the one cycle after every end-of-frame edge, including back-to-back frames.
- Reset mid-frame: at the next edge rs232_tx=1, the FIFO is flushed, and no flag_tx_end pulse is issued. The partial frame is abandoned.

## Timing
- Let edge k be the edge that samples tx_trig=1 while the block is IDLE with an empty FIFO.
  - Byte written at k.
  - Start bit on rs232_tx from edge k+1.
  - Data bit i from edge k+1+(i+1)·BAUD_END.
  - Stop bit from k+1+9·BAUD_END.
  - Frame ends at edge k+1+10·BAUD_END. flag_tx_end is high for the cycle following that edge.
- Back-to-back throughput is exactly 10·BAUD_END cycles per byte.
- tx_full asserts at the edge where count reaches depth. It deasserts at the edge of the next pop.

## Test plan
Use BAUD_END=16 and FIFO_AW=2 for simulation.
- **Single byte:** write 0x55 at edge k → rs232_tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 16 cycles, starting at edge k+1. flag_tx_end pulses once after edge k+161. tx_busy is high on edges k+1..k+160.
- **Back-to-back:** write 0xA5 then 0x3C on consecutive cycles → 20 contiguous bits with no high gap between stop and start. Two flag_tx_end pulses 160 cycles apart. tx_busy never drops between frames.
- **Overflow:** write 0x01..0x06 on six consecutive edges k..k+5 → tx_full rises at k+4 and 0x06 is dropped. Line carries 0x01..0x05 in order. tx_full falls at k+161.
- **Extremes:** send 0x00 then 0xFF → data bits all 0 then all 1. The stop bit is 1 in both frames. After the last frame, rs232_tx stays 1 indefinitely.
- **Reset mid-frame:** write 0x00, 0x00. Assert rst for 1 cycle during bit 4 of the first frame → rs232_tx=1, tx_busy=0, tx_full=0 at the next edge. No flag_tx_end and no second frame. A subsequent write of 0x81 transmits correctly.
- **Idle strobe check:** hold tx_trig=0 for 1000 cycles after reset → rs232_tx=1 and all flags 0 throughout.
